// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture
// Captures frames from an 8x8 multiplexed scan driver. Rows and columns are
// synchronized, polarity-normalized, and sampled once per stable row
// interval. A small HUNT/CAPTURE FSM assembles rows 0..7 into a shadow
// register and publishes the whole frame atomically on data/data_valid.
//
// Handshake: data_valid is a one-cycle pulse with no ready; data holds the
// last complete frame and changes only in the cycle data_valid is high.
// frame_err is a one-cycle pulse when a partially captured frame is dropped.
// The two pulses are never high together.
module matrix_scan_capture #(
  parameter int unsigned SETTLE         = 4,
  parameter bit          ROW_ACTIVE_LOW = 1'b0,
  parameter bit          COL_ACTIVE_LOW = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rows,
  input  logic [7:0]  columns,
  output logic [63:0] data,
  output logic        data_valid,
  output logic        frame_err,
  output logic [2:0]  row_idx
);

  typedef enum logic {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  // Synchronizer stages
  logic [7:0] rows_s1, rows_s2;
  logic [7:0] cols_s1, cols_s2;

  // Normalized (1 = active row / lit column) views of the synchronized inputs
  logic [7:0] rows_n;
  logic [7:0] cols_n;

  // Settle tracking
  logic [7:0] rows_prev;
  logic [7:0] settle_cnt;
  logic       sample_evt;

  // Row decode
  logic       row_ok;
  logic [2:0] row_i;

  // FSM and datapath state
  state_t      state_q, state_d;
  logic [2:0]  exp_q, exp_d;
  logic [63:0] shadow_q, shadow_d;
  logic [63:0] data_d;
  logic        dv_d, err_d;
  logic [2:0]  idx_d;

  // Index of the highest set bit; only meaningful when the value is one-hot.
  function automatic logic [2:0] onehot_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Two-flop synchronizers for the asynchronous scan inputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rows_s1 <= 8'd0;
      rows_s2 <= 8'd0;
      cols_s1 <= 8'd0;
      cols_s2 <= 8'd0;
    end else begin
      rows_s1 <= rows;
      rows_s2 <= rows_s1;
      cols_s1 <= columns;
      cols_s2 <= cols_s1;
    end
  end

  assign rows_n = ROW_ACTIVE_LOW ? ~rows_s2 : rows_s2;
  assign cols_n = COL_ACTIVE_LOW ? ~cols_s2 : cols_s2;

  // Settle counter: restarts on any row change, saturates at SETTLE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rows_prev  <= 8'd0;
      settle_cnt <= 8'd0;
    end else begin
      rows_prev <= rows_n;
      if (rows_n != rows_prev) begin
        settle_cnt <= 8'd0;
      end else if (settle_cnt != SETTLE_C) begin
        settle_cnt <= settle_cnt + 8'd1;
      end
    end
  end

  // Fires in the single cycle where the counter steps up to SETTLE
  assign sample_evt = (rows_n == rows_prev) && (settle_cnt == SETTLE_M1);
  assign row_ok     = (rows_n != 8'd0) && ((rows_n & (rows_n - 8'd1)) == 8'd0);
  assign row_i      = onehot_index(rows_n);

  // FSM state and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= HUNT;
      exp_q      <= 3'd0;
      shadow_q   <= 64'd0;
      data       <= 64'd0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      row_idx    <= 3'd0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      shadow_q   <= shadow_d;
      data       <= data_d;
      data_valid <= dv_d;
      frame_err  <= err_d;
      row_idx    <= idx_d;
    end
  end

  // Next-state logic: row ordering, shadow writes, frame publish and abort
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    data_d   = data;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    idx_d    = row_idx;

    // Blanking (no row active) is ignored entirely
    if (sample_evt && (rows_n != 8'd0)) begin
      if (row_ok) idx_d = row_i;

      case (state_q)
        HUNT: begin
          // Only row 0 can start a frame; everything else is silently skipped
          if (row_ok && (row_i == 3'd0)) begin
            shadow_d = {56'd0, cols_n};
            exp_d    = 3'd1;
            state_d  = CAPTURE;
          end
        end

        CAPTURE: begin
          if (row_ok && (row_i == exp_q)) begin
            shadow_d[{exp_q, 3'b000} +: 8] = cols_n;
            if (exp_q == 3'd7) begin
              // Publish the frame including row 7 in one update
              data_d   = shadow_d;
              dv_d     = 1'b1;
              shadow_d = 64'd0;
              exp_d    = 3'd0;
              state_d  = HUNT;
            end else begin
              exp_d = exp_q + 3'd1;
            end
          end else if (row_ok && (row_i == (exp_q - 3'd1))) begin
            // Driver re-strobed the row just captured: tolerate it
            exp_d = exp_q;
          end else begin
            err_d = 1'b1;
            if (row_ok && (row_i == 3'd0)) begin
              // Row 0 both aborts the old frame and starts a new one
              shadow_d = {56'd0, cols_n};
              exp_d    = 3'd1;
              state_d  = CAPTURE;
            end else begin
              shadow_d = 64'd0;
              exp_d    = 3'd0;
              state_d  = HUNT;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Bench for matrix_scan_capture: one active-high instance and one active-low
// instance driven with the bit-inverted stimulus, both checked against the
// same hand-computed expectations.
module tb_matrix_scan_capture;

  localparam int SETTLE = 4;
  localparam logic [63:0] DIAG = 64'h8040201008040201;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus
  logic [7:0] rows, columns;
  logic [7:0] rows_inv, cols_inv;
  assign rows_inv = ~rows;
  assign cols_inv = ~columns;

  // DUT outputs
  logic [63:0] data_a, data_b;
  logic        dv_a, dv_b, err_a, err_b;
  logic [2:0]  idx_a, idx_b;

  matrix_scan_capture #(.SETTLE(SETTLE), .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)) dut_a (
    .CLK(clk), .RST(rst), .rows(rows), .columns(columns),
    .data(data_a), .data_valid(dv_a), .frame_err(err_a), .row_idx(idx_a)
  );

  matrix_scan_capture #(.SETTLE(SETTLE), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)) dut_b (
    .CLK(clk), .RST(rst), .rows(rows_inv), .columns(cols_inv),
    .data(data_b), .data_valid(dv_b), .frame_err(err_b), .row_idx(idx_b)
  );

  // Scoreboard counters
  int checks = 0;
  int errors = 0;
  int dv_cnt_a = 0, dv_cnt_b = 0, err_cnt_a = 0, err_cnt_b = 0;
  logic [63:0] prev_a = 64'd0, prev_b = 64'd0;

  typedef struct {
    logic [7:0]  rows;
    logic [7:0]  cols;
    int          hold;
    int          exp_dv;
    int          exp_err;
    logic [63:0] exp_data;
    logic [2:0]  exp_idx;
  } step_t;

  step_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pulse counting plus continuous properties, sampled just after each edge
  always @(posedge clk) begin
    #1;
    if (dv_a)  dv_cnt_a++;
    if (dv_b)  dv_cnt_b++;
    if (err_a) err_cnt_a++;
    if (err_b) err_cnt_b++;
    checks++;
    if ((dv_a && err_a) || (dv_b && err_b)) begin
      errors++;
      $display("FAIL pulse_overlap at %0t: dv_a=%b err_a=%b dv_b=%b err_b=%b, required never both",
               $time, dv_a, err_a, dv_b, err_b);
    end
    if (!rst && (((data_a !== prev_a) && !dv_a) || ((data_b !== prev_b) && !dv_b))) begin
      errors++;
      $display("FAIL data_change_without_valid at %0t: a=%h b=%h", $time, data_a, data_b);
    end
    prev_a = data_a;
    prev_b = data_b;
  end

  task automatic add_step(input logic [7:0] r, input logic [7:0] c, input int hold,
                          input int dv, input int er, input logic [63:0] d, input logic [2:0] idx);
    step_t s;
    s.rows = r; s.cols = c; s.hold = hold; s.exp_dv = dv; s.exp_err = er;
    s.exp_data = d; s.exp_idx = idx;
    tbl.push_back(s);
  endtask

  // Driver: call at a negedge; returns at a negedge after checking the step
  task automatic run_step(input step_t s, input string tag);
    int dva, dvb, era, erb;
    dva = dv_cnt_a; dvb = dv_cnt_b; era = err_cnt_a; erb = err_cnt_b;
    rows = s.rows;
    columns = s.cols;
    repeat (s.hold) @(negedge clk);
    check({tag, "_dv_a"},   64'(dv_cnt_a - dva),  64'(s.exp_dv));
    check({tag, "_dv_b"},   64'(dv_cnt_b - dvb),  64'(s.exp_dv));
    check({tag, "_err_a"},  64'(err_cnt_a - era), 64'(s.exp_err));
    check({tag, "_err_b"},  64'(err_cnt_b - erb), 64'(s.exp_err));
    check({tag, "_data_a"}, data_a, s.exp_data);
    check({tag, "_data_b"}, data_b, s.exp_data);
    check({tag, "_idx_a"},  64'(idx_a), 64'(s.exp_idx));
    check({tag, "_idx_b"},  64'(idx_b), 64'(s.exp_idx));
  endtask

  task automatic quick_step(input logic [7:0] r, input logic [7:0] c, input int dv,
                            input logic [63:0] d, input logic [2:0] idx, input string tag);
    step_t s;
    s.rows = r; s.cols = c; s.hold = 10; s.exp_dv = dv; s.exp_err = 0;
    s.exp_data = d; s.exp_idx = idx;
    run_step(s, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_a"}, data_a, 64'd0);
    check({tag, "_data_b"}, data_b, 64'd0);
    check({tag, "_flags_a"}, {dv_a, err_a, idx_a}, 64'd0);
    check({tag, "_flags_b"}, {dv_b, err_b, idx_b}, 64'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] one;
    int n;
    int dva;

    rst = 1'b1;
    rows = 8'h00;
    columns = 8'h00;
    one = 8'h01;
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Diagonal frame
    for (int i = 0; i < 8; i++)
      add_step(one << i, one << i, 10, (i == 7) ? 1 : 0, 0, (i == 7) ? DIAG : 64'd0, 3'(i));

    // Rows 0,1,2 then 4: abort, data kept; then clean 0xAA frame
    for (int i = 0; i < 3; i++) add_step(one << i, 8'hFF, 10, 0, 0, DIAG, 3'(i));
    add_step(8'h10, 8'hFF, 10, 0, 1, DIAG, 3'd4);
    for (int i = 0; i < 8; i++)
      add_step(one << i, 8'hAA, 10, (i == 7) ? 1 : 0, 0,
               (i == 7) ? 64'hAAAAAAAAAAAAAAAA : DIAG, 3'(i));

    // Blanking between rows and row 3 strobed twice
    for (int i = 0; i < 8; i++) begin
      add_step(one << i, 8'hC0 + 8'(i), 10, (i == 7) ? 1 : 0, 0,
               (i == 7) ? 64'hC7C6C5C4C3C2C1C0 : 64'hAAAAAAAAAAAAAAAA, 3'(i));
      add_step(8'h00, 8'h00, 20, 0, 0,
               (i == 7) ? 64'hC7C6C5C4C3C2C1C0 : 64'hAAAAAAAAAAAAAAAA, 3'(i));
      if (i == 3) begin
        add_step(8'h08, 8'hC3, 10, 0, 0, 64'hAAAAAAAAAAAAAAAA, 3'd3);
        add_step(8'h00, 8'h00, 20, 0, 0, 64'hAAAAAAAAAAAAAAAA, 3'd3);
      end
    end

    // Multi-hot row during capture
    add_step(8'h01, 8'hEE, 10, 0, 0, 64'hC7C6C5C4C3C2C1C0, 3'd0);
    add_step(8'h02, 8'hEE, 10, 0, 0, 64'hC7C6C5C4C3C2C1C0, 3'd1);
    add_step(8'h03, 8'hEE, 10, 0, 1, 64'hC7C6C5C4C3C2C1C0, 3'd1);

    // Row 0 mid-frame aborts and restarts in the same event
    for (int i = 0; i < 3; i++) add_step(one << i, 8'hEE, 10, 0, 0, 64'hC7C6C5C4C3C2C1C0, 3'(i));
    add_step(8'h01, 8'h00, 10, 0, 1, 64'hC7C6C5C4C3C2C1C0, 3'd0);
    for (int i = 1; i < 8; i++)
      add_step(one << i, 8'h11 * 8'(i), 10, (i == 7) ? 1 : 0, 0,
               (i == 7) ? 64'h7766554433221100 : 64'hC7C6C5C4C3C2C1C0, 3'(i));

    foreach (tbl[k]) run_step(tbl[k], $sformatf("step%0d", k));

    // Column glitches during the first cycles of each row
    dva = dv_cnt_a;
    for (int i = 0; i < 8; i++) begin
      rows = one << i;
      for (int c = 0; c < 3; c++) begin
        columns = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
      columns = 8'h5A;
      repeat (7) @(negedge clk);
      if (i < 7) check($sformatf("glitch_row%0d_data_a", i), data_a, 64'h7766554433221100);
    end
    check("glitch_dv_count", 64'(dv_cnt_a - dva), 64'd1);
    check("glitch_data_a", data_a, 64'h5A5A5A5A5A5A5A5A);
    check("glitch_data_b", data_b, 64'h5A5A5A5A5A5A5A5A);

    // Latency from row 7 input change to data_valid
    for (int i = 0; i < 7; i++)
      quick_step(one << i, 8'h33, 0, 64'h5A5A5A5A5A5A5A5A, 3'(i), $sformatf("lat_row%0d", i));
    rows = 8'h80;
    columns = 8'h33;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (dv_a) break;
    end
    check("latency_cycles", 64'(n), 64'(3 + SETTLE));
    check("latency_dv_b", 64'(dv_b), 64'd1);
    check("latency_data_a", data_a, 64'h3333333333333333);
    @(negedge clk);
    repeat (3) @(negedge clk);

    // Reset during a frame: immediate clear, no frame until a full new one
    for (int i = 0; i < 3; i++)
      quick_step(one << i, 8'h44, 0, 64'h3333333333333333, 3'(i), $sformatf("rst_pre%0d", i));
    rows = 8'h08;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 3; i < 8; i++)
      quick_step(one << i, 8'h44, 0, 64'd0, 3'(i), $sformatf("rst_post%0d", i));
    for (int i = 0; i < 8; i++)
      quick_step(one << i, one << i, (i == 7) ? 1 : 0, (i == 7) ? DIAG : 64'd0, 3'(i),
                 $sformatf("rst_frame%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan_capture.md
MATRIX_SCAN_CAPTURE -- requirements
Module: matrix_scan_capture

Interface
REQ-001 Parameter SETTLE, default 4: number of consecutive CLK cycles a row pattern must stay unchanged before its columns are sampled; legal range 1..255.
REQ-002 Parameter ROW_ACTIVE_LOW, default 0: 1 means an active row is 0 on the rows input.
REQ-003 Parameter COL_ACTIVE_LOW, default 0: 1 means a lit column is 0 on the columns input.
REQ-004 CLK  input  1: the single clock; all logic is on its rising edge.
REQ-005 RST  input  1: asynchronous, active-high reset.
REQ-006 rows  input  8: row strobes from an 8x8 scan driver; asynchronous to CLK.
REQ-007 columns  input  8: column data for the currently strobed row; asynchronous to CLK.
REQ-008 data  output  64: last complete captured frame.
REQ-009 data_valid  output  1: one-cycle pulse when data is updated.
REQ-010 frame_err  output  1: one-cycle pulse when a frame is abandoned.
REQ-011 row_idx  output  3: index of the most recently sampled row (debug).

Function
REQ-012 rows and columns SHALL each pass through a 2-flop synchronizer; every later reference to them means the synchronized value.
REQ-013 Polarity SHALL be normalized after synchronization, so a normalized 1 means "row active" or "column lit".
REQ-014 A settle counter SHALL reset to 0 when the normalized rows value differs from its value on the previous cycle, and otherwise increment, saturating at SETTLE.
REQ-015 A row sample event SHALL fire exactly once per stable interval, on the cycle the settle counter reaches SETTLE.
REQ-016 At a sample event, normalized rows == 0 (blanking) SHALL be ignored, with no state change.
REQ-017 At a sample event, a normalized rows value with more than one bit set SHALL be an invalid pattern.
REQ-018 A one-hot rows value with bit i set SHALL give row index i.
REQ-019 The sampled row i SHALL write the normalized columns into shadow bits [8*i+7:8*i], with column bit j going to shadow bit 8*i+j.
REQ-020 FSM states SHALL be HUNT and CAPTURE; the expected-row register is 3 bits wide.
REQ-021 In HUNT: row 0 sampled -> write shadow row 0, expected = 1, go to CAPTURE; any other row or an invalid pattern -> stay in HUNT, no error.
REQ-022 In CAPTURE, row == expected and expected < 7 -> write that shadow row and increment expected.
REQ-023 In CAPTURE, row == expected == 7 -> write shadow row 7; the next cycle, data = full shadow with row 7 included and data_valid = 1; then go to HUNT.
REQ-024 In CAPTURE, the same row sampled again (row == expected-1) SHALL be ignored, to tolerate a driver re-strobing a row.
REQ-025 In CAPTURE, any other row or an invalid pattern -> frame_err = 1 for one cycle, shadow discarded, go to HUNT.
REQ-026 When row 0 is the row that causes a CAPTURE abort, it SHALL also restart the capture in the same event, leaving state = CAPTURE and expected = 1.
REQ-027 The data output SHALL change only on data_valid cycles, and all 64 bits SHALL change together.
REQ-028 data_valid and frame_err SHALL never be asserted in the same cycle.
REQ-029 row_idx SHALL update on every valid one-hot sample event.
REQ-030 Latency: data_valid SHALL rise exactly 2 + SETTLE + 1 CLK cycles after the rows input changes to row 7, with row 7 held stable.

Reset
REQ-031 While RST = 1 (asynchronous assert): state = HUNT; expected = 0; shadow, synchronizers, settle counter, data and row_idx = 0; data_valid = frame_err = 0.
REQ-032 Reset deassertion mid-frame SHALL restart in HUNT, so no partial frame is ever presented.

Verification
REQ-033 Rows 0..7 in order, each held 10 cycles, columns = 8'h01<<i, SETTLE=4 -> one data_valid pulse, data = 64'h8040201008040201, frame_err = 0.
REQ-034 Rows 0,1,2 then 4, SETTLE=4 -> frame_err pulse at the row-4 sample event; data unchanged; the next clean frame with all columns = 8'hAA gives data = 64'hAAAAAAAAAAAAAAAA.
REQ-035 Columns change during the first 3 cycles of each row, then settle to 8'h5A, SETTLE=4 -> data = 64'h5A5A5A5A5A5A5A5A; glitch values never appear in data.
REQ-036 Clean frame with rows blanked to 0 for 20 cycles between rows, plus row 3 strobed twice -> data_valid pulse with the correct data, no frame_err.
REQ-037 rows = 8'h03 during CAPTURE -> frame_err pulse; RST asserted during a frame -> all outputs 0 immediately, and no data_valid until a full new frame 0..7.
REQ-038 ROW_ACTIVE_LOW=1, COL_ACTIVE_LOW=1, inverted stimulus of REQ-033 -> data = 64'h8040201008040201.
